phy_rx_demux: RTL and testbench

- Receive-side counterpart of the 4-lane PHY serializer.
- Takes one 9-bit word per clk_4f cycle (bit 8 = valid, bits 7:0 = payload) and aligns to a reserved COM symbol on lane 0.
- Distributes words round-robin into four lane registers and presents a complete 4-lane frame with a one-cycle strobe.
- Sits between the serial PHY link and the per-lane receive FIFOs.

---
 rtl/phy_rx_demux.sv | 74 +++++++
 tb/tb_phy_rx_demux.sv | 125 ++++++++++++
 2 files changed

// File: rtl/phy_rx_demux.sv
// phy_rx_demux: aligns a serial 9-bit word stream to COM on lane 0 and regroups it into 4-lane frames
module phy_rx_demux #(
  parameter logic [7:0] COM_SYM = 8'hBC,
  parameter logic [3:0] LOSS_THRESH = 4'd4
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [8:0] in_data,
  output logic [8:0] data0,
  output logic [8:0] data1,
  output logic [8:0] data2,
  output logic [8:0] data3,
  output logic       out_strobe,
  output logic       aligned,
  output logic [7:0] err_count
);
  typedef enum logic {SEARCH, ALIGNED} state_t;
  state_t state, state_nxt;
  logic [1:0] lane_cnt;
  logic [3:0] miss_cnt, miss_inc;
  logic [8:0] shadow [4];
  logic [8:0] word;
  logic com, misplaced, drop, strobe_nxt;
  assign com = in_data[8] & (in_data[7:0] == COM_SYM);
  assign aligned = (state == ALIGNED);
  always_comb begin
    word = in_data[8] ? in_data : {1'b0, shadow[lane_cnt][7:0]};
    misplaced = (state == ALIGNED) && com && (lane_cnt != 2'd0);
    miss_inc = miss_cnt + 4'd1;
    drop = misplaced && (miss_inc == LOSS_THRESH);
    strobe_nxt = (state == ALIGNED) && (lane_cnt == 2'd3) && !drop;
    state_nxt = (state == SEARCH) ? (com ? ALIGNED : SEARCH) : (drop ? SEARCH : ALIGNED);
  end
  always_ff @(posedge clk_4f or negedge reset)
    if (!reset) state <= SEARCH;
    else state <= state_nxt;
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      data0 <= '0;
      data1 <= '0;
      data2 <= '0;
      data3 <= '0;
      out_strobe <= 1'b0;
      err_count <= '0;
      lane_cnt <= '0;
      miss_cnt <= '0;
      for (int i = 0; i < 4; i++) shadow[i] <= '0;
    end else begin
      out_strobe <= strobe_nxt;
      if (misplaced && err_count != 8'hFF) err_count <= err_count + 8'd1;
      if (state == SEARCH) begin
        if (com) begin
          shadow[0] <= in_data;
          lane_cnt <= 2'd1;
          miss_cnt <= '0;
        end
      end else if (drop) begin
        lane_cnt <= '0;
        miss_cnt <= '0;
      end else begin
        shadow[lane_cnt] <= word;
        lane_cnt <= lane_cnt + 2'd1;
        if (com) miss_cnt <= misplaced ? miss_inc : 4'd0;
      end
      // lane 3 bypasses its shadow so the frame appears one cycle after its last word
      if (strobe_nxt) begin
        data0 <= shadow[0];
        data1 <= shadow[1];
        data2 <= shadow[2];
        data3 <= word;
      end
    end
  end
endmodule

// File: tb/tb_phy_rx_demux.sv
// tb_phy_rx_demux: directed stimulus with a frame scoreboard checked on every strobe
module tb_phy_rx_demux;
  logic clk_4f = 1'b0;
  logic reset = 1'b0;
  logic [8:0] in_data = '0;
  logic [8:0] data0, data1, data2, data3;
  logic out_strobe, aligned;
  logic [7:0] err_count;
  int n_tests = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;
  logic [35:0] q[$];

  phy_rx_demux dut (
    .clk_4f(clk_4f), .reset(reset), .in_data(in_data),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .out_strobe(out_strobe), .aligned(aligned), .err_count(err_count)
  );

  always #5 clk_4f = ~clk_4f;

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [8:0] w, input logic es);
    @(negedge clk_4f);
    in_data = w;
    @(posedge clk_4f);
    #1;
    chk("strobe", 36'(out_strobe), 36'(es));
  endtask

  always @(posedge clk_4f) begin
    #1;
    if (chk_en && out_strobe) begin
      if (q.size() == 0) chk("unexpected_strobe", 36'(out_strobe), 36'd0);
      else chk("frame", {data0, data1, data2, data3}, q.pop_front());
    end
  end

  task automatic chk_zero(input string tag);
    chk(tag, {data0, data1, data2, data3}, 36'd0);
    chk({tag, "_ctl"}, {out_strobe, aligned, err_count}, 36'd0);
  endtask

  initial begin
    @(posedge clk_4f);
    #1;
    chk_zero("reset");
    @(negedge clk_4f);
    reset = 1'b1;
    chk_en = 1'b1;
    // lock
    q.push_back({9'h1BC, 9'h111, 9'h122, 9'h133});
    send(9'h1BC, 1'b0);
    chk("aligned_lock", 36'(aligned), 36'd1);
    send(9'h111, 1'b0);
    send(9'h122, 1'b0);
    send(9'h133, 1'b1);
    // steady stream
    for (int k = 0; k < 3; k++) begin
      q.push_back({9'h1BC, 9'(9'h1A0 + k), 9'(9'h1B0 + k), 9'(9'h1C0 + k)});
      send(9'h1BC, 1'b0);
      send(9'(9'h1A0 + k), 1'b0);
      send(9'(9'h1B0 + k), 1'b0);
      send(9'(9'h1C0 + k), 1'b1);
    end
    chk("err_steady", 36'(err_count), 36'd0);
    // invalid word keeps payload, clears valid
    q.push_back({9'h1BC, 9'h111, 9'h155, 9'h133});
    q.push_back({9'h1BC, 9'h1A1, 9'h055, 9'h1C1});
    send(9'h1BC, 1'b0); send(9'h111, 1'b0); send(9'h155, 1'b0); send(9'h133, 1'b1);
    send(9'h1BC, 1'b0); send(9'h1A1, 1'b0); send(9'h0FF, 1'b0); send(9'h1C1, 1'b1);
    // loss of alignment: COM on lane 2, lane 0 never carries COM
    for (int k = 0; k < 3; k++) begin
      q.push_back({9'h100, 9'h1A1, 9'h1BC, 9'h1C1});
      send(9'h100, 1'b0); send(9'h1A1, 1'b0); send(9'h1BC, 1'b0); send(9'h1C1, 1'b1);
      chk("err_loss", 36'(err_count), 36'(k + 1));
      chk("aligned_loss", 36'(aligned), 36'd1);
    end
    send(9'h100, 1'b0); send(9'h1A1, 1'b0); send(9'h1BC, 1'b0);
    chk("aligned_drop", 36'(aligned), 36'd0);
    chk("err_drop", 36'(err_count), 36'd4);
    send(9'h1C1, 1'b0);
    // pre-lock garbage then relock
    send(9'h101, 1'b0);
    send(9'h1FF, 1'b0);
    send(9'h0BC, 1'b0);
    chk("aligned_garbage", 36'(aligned), 36'd0);
    q.push_back({9'h1BC, 9'h1A5, 9'h1B5, 9'h1C5});
    send(9'h1BC, 1'b0);
    chk("aligned_relock", 36'(aligned), 36'd1);
    send(9'h1A5, 1'b0); send(9'h1B5, 1'b0); send(9'h1C5, 1'b1);
    // 300 misplaced COMs: every lane carries COM, lane 0 keeps clearing the miss count
    chk_en = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_4f);
      in_data = 9'h1BC;
      @(posedge clk_4f);
      #1;
      if (i == 99) chk("err_mid", 36'(err_count), 36'd79);
    end
    chk("err_sat", 36'(err_count), 36'd255);
    chk("aligned_sat", 36'(aligned), 36'd1);
    @(negedge clk_4f);
    chk_en = 1'b1;
    send(9'h1BC, 1'b0);
    send(9'h111, 1'b0);
    // asynchronous reset mid-frame, between edges
    @(negedge clk_4f);
    #2 reset = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk_4f);
    reset = 1'b1;
    chk("queue_empty", 36'(q.size()), 36'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
